// File: rtl/sort_controller.sv
// Moore FSM sequencing an exchange-sort datapath (i/j pointers, A/B operands, comparator).
// Optional feature macro: SORT_SWAP_CNT_EN adds a saturating swap counter output swap_cnt.
module sort_controller #(
    parameter int ADDR_W     = 8,
    parameter int MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        gt,
    input  logic        co1,
    input  logic        co2,
    output logic        inzP1,
    output logic        incP1,
    output logic        inzP2,
    output logic        incP2,
    output logic        ldP2,
    output logic        ldA,
    output logic        ldB,
    output logic        addr_sel,
    output logic        wr_sel,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        busy,
    output logic        done
`ifdef SORT_SWAP_CNT_EN
    ,
    output logic [15:0] swap_cnt
`endif
);

    if (ADDR_W != 8) begin : g_bad_addr_w
        $error("sort_controller: ADDR_W must be 8");
    end
    if (MEM_RD_LAT != 1) begin : g_bad_rd_lat
        $error("sort_controller: only MEM_RD_LAT = 1 is supported");
    end

    // S_WR_J_AB is a second WR_J that remembers an abort seen in WR_I.
    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_RD_I, S_RD_J, S_LD_B, S_CMP, S_WR_I,
        S_WR_J, S_WR_J_AB, S_ADV_J, S_CHK_J, S_ADV_I, S_SET_J, S_DONE
    } state_e;

    state_e state_q, state_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        state_d  = state_q;
        inzP1    = 1'b0;
        incP1    = 1'b0;
        inzP2    = 1'b0;
        incP2    = 1'b0;
        ldP2     = 1'b0;
        ldA      = 1'b0;
        ldB      = 1'b0;
        addr_sel = 1'b0;
        wr_sel   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  if (start) state_d = S_INIT;
            S_INIT:  begin inzP1 = 1'b1; inzP2 = 1'b1; state_d = S_RD_I; end
            S_RD_I:  begin mem_rd = 1'b1; state_d = S_RD_J; end
            S_RD_J:  begin mem_rd = 1'b1; addr_sel = 1'b1; ldA = 1'b1; state_d = S_LD_B; end
            S_LD_B:  begin ldB = 1'b1; state_d = S_CMP; end
            S_CMP:   state_d = gt ? S_WR_I : S_ADV_J;
            S_WR_I:  begin
                mem_wr  = 1'b1;
                wr_sel  = 1'b1;
                state_d = abort ? S_WR_J_AB : S_WR_J;
            end
            S_WR_J:    begin mem_wr = 1'b1; addr_sel = 1'b1; state_d = S_ADV_J; end
            S_WR_J_AB: begin mem_wr = 1'b1; addr_sel = 1'b1; state_d = S_IDLE; end
            S_ADV_J: begin incP2 = 1'b1; state_d = S_CHK_J; end
            S_CHK_J: state_d = co2 ? S_ADV_I : S_RD_I;
            S_ADV_I: begin incP1 = 1'b1; state_d = S_SET_J; end
            S_SET_J: begin ldP2 = 1'b1; state_d = co1 ? S_DONE : S_RD_I; end
            S_DONE:  begin done = 1'b1; state_d = S_IDLE; end
            default: state_d = S_IDLE;
        endcase
        // A swap in flight (WR_I) is finished before the abort is honoured.
        if (abort && state_q != S_IDLE && state_q != S_WR_I) state_d = S_IDLE;
    end

`ifdef SORT_SWAP_CNT_EN
    logic [15:0] swap_cnt_q, swap_cnt_d;

    always_comb begin
        swap_cnt_d = swap_cnt_q;
        if (state_q == S_INIT)
            swap_cnt_d = '0;
        else if ((state_q == S_WR_J || state_q == S_WR_J_AB) && swap_cnt_q != 16'hFFFF)
            swap_cnt_d = swap_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) swap_cnt_q <= '0;
        else      swap_cnt_q <= swap_cnt_d;
    end

    assign swap_cnt = swap_cnt_q;
`endif

endmodule

// File: tb/tb_sort_controller.sv
// Self-checking bench for sort_controller with a behavioural datapath/memory model.
// The model shrinks the table to N entries (co1 at i==N-1, j wraps at N) to keep runs short.
module tb_sort_controller;

    localparam int N        = 32;
    localparam int PAIRS    = 496;   // N*(N-1)/2
    localparam int BASE_CYC = 3040;  // 1 + 6*496 + 2*31 + 1
    localparam int REV_CYC  = 4032;  // BASE_CYC + 2*496 swaps

    localparam logic [12:0] O_DONE  = 13'h0001, O_BUSY  = 13'h0002, O_MEMWR = 13'h0004,
                            O_MEMRD = 13'h0008, O_WRSEL = 13'h0010, O_ASEL  = 13'h0020,
                            O_LDB   = 13'h0040, O_LDA   = 13'h0080, O_LDP2  = 13'h0100,
                            O_INCP2 = 13'h0200, O_INZP2 = 13'h0400, O_INCP1 = 13'h0800,
                            O_INZP1 = 13'h1000;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic gt, co1, co2;
    logic inzP1, incP1, inzP2, incP2, ldP2, ldA, ldB, addr_sel, wr_sel, mem_rd, mem_wr, busy, done;
`ifdef SORT_SWAP_CNT_EN
    logic [15:0] swap_cnt;
`endif

    sort_controller dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .gt(gt), .co1(co1), .co2(co2),
        .inzP1(inzP1), .incP1(incP1), .inzP2(inzP2), .incP2(incP2), .ldP2(ldP2),
        .ldA(ldA), .ldB(ldB), .addr_sel(addr_sel), .wr_sel(wr_sel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .done(done)
`ifdef SORT_SWAP_CNT_EN
        , .swap_cnt(swap_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [12:0] outs;
    assign outs = {inzP1, incP1, inzP2, incP2, ldP2, ldA, ldB, addr_sel, wr_sel, mem_rd, mem_wr, busy, done};

    // ---------------- datapath model ----------------
    logic [7:0]  i_q = 8'd0, j_q = 8'd0, addr;
    logic [15:0] a_q = 16'd0, b_q = 16'd0, rdata_q = 16'd0;
    logic [15:0] mem [N];
    logic [15:0] img [N];
    logic        load_mem = 1'b0;

    assign addr = addr_sel ? j_q : i_q;
    assign gt   = (a_q > b_q);
    assign co1  = (i_q == 8'(N - 1));
    assign co2  = (j_q == 8'd0);

    always @(posedge clk) begin
        if (load_mem) for (int k = 0; k < N; k++) mem[k] <= img[k];
        if (mem_rd) rdata_q <= mem[addr[4:0]];
        if (mem_wr) mem[addr[4:0]] <= wr_sel ? b_q : a_q;
        if (ldA) a_q <= rdata_q;
        if (ldB) b_q <= rdata_q;
        if (inzP1) i_q <= 8'd0;
        if (incP1) i_q <= i_q + 8'd1;
        if (inzP2) j_q <= 8'd1;
        if (incP2) j_q <= (j_q == 8'(N - 1)) ? 8'd0 : j_q + 8'd1;
        if (ldP2)  j_q <= (i_q == 8'(N - 1)) ? 8'd0 : i_q + 8'd1;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int cycles;
        int writes;
    } done_exp_t;

    done_exp_t   done_q[$];
    logic [15:0] ptr_q[$];
    int checks = 0, errors = 0;
    int cyc_cnt = 0, wr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        done_exp_t   e;
        logic [15:0] p;
        if (inzP1) begin
            cyc_cnt = 1;
            wr_cnt  = 0;
        end else if (busy) begin
            cyc_cnt++;
        end
        if (mem_wr) wr_cnt++;
        if (mem_rd && addr_sel && ptr_q.size() > 0) begin
            p = ptr_q.pop_front();
            check("ptr_ij", {16'd0, i_q, j_q}, {16'd0, p});
        end
        if (done) begin
            check("done_expected", 32'(done_q.size() != 0), 32'd1);
            if (done_q.size() != 0) begin
                e = done_q.pop_front();
                check("done_cycles", cyc_cnt, e.cycles);
                check("done_writes", wr_cnt, e.writes);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input int mode);
        for (int k = 0; k < N; k++)
            img[k] = (mode == 0) ? 16'(k) : (mode == 1) ? 16'(N - 1 - k) : 16'h00AA;
        @(negedge clk) load_mem = 1'b1;
        @(negedge clk) load_mem = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_outs(input string name, input logic [12:0] mask, input logic [12:0] val,
                             input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if ((outs & mask) == val) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic check_sorted(input string name);
        for (int k = 0; k < N; k++) check(name, 32'(mem[k]), 32'(k));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(outs), 32'd0);
        rst = 1'b1;

        // Reset asserted mid-RD_J clears outputs without waiting for a clock.
        load(0);
        pulse_start();
        wait_outs("reach_rd_j", O_LDA, O_LDA, 10);
        rst = 1'b0;
        #1 check("async_reset_outputs", 32'(outs), 32'd0);
        @(negedge clk) rst = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("idle_quiet", 32'(outs), 32'd0);
        end

        // Already sorted: no writes, base cycle count.
        load(0);
        done_q.push_back('{BASE_CYC, 0});
        pulse_start();
        wait_outs("sorted_done", O_DONE, O_DONE, 4000);
        check_sorted("sorted_mem");
`ifdef SORT_SWAP_CNT_EN
        check("sorted_swap_cnt", 32'(swap_cnt), 32'd0);
`endif

        // Reverse order: every pair swaps.
        load(1);
        done_q.push_back('{REV_CYC, 2 * PAIRS});
        pulse_start();
        wait_outs("reverse_done", O_DONE, O_DONE, 5000);
        check_sorted("reverse_mem");
`ifdef SORT_SWAP_CNT_EN
        check("reverse_swap_cnt", 32'(swap_cnt), 32'(PAIRS));
`endif

        // Equal keys: no swaps, pointer walk checked on every read pair.
        load(2);
        done_q.push_back('{BASE_CYC, 0});
        for (int i = 0; i < N - 1; i++)
            for (int j = i + 1; j < N; j++) ptr_q.push_back({8'(i), 8'(j)});
        pulse_start();
        wait_outs("equal_done", O_DONE, O_DONE, 4000);
        check("equal_ptr_drained", 32'(ptr_q.size()), 32'd0);
        for (int k = 0; k < N; k++) check("equal_mem", 32'(mem[k]), 32'h00AA);

        // Abort in CMP of the first pair: straight to IDLE, no write.
        load(1);
        pulse_start();
        wait_outs("reach_ld_b", O_LDB, O_LDB, 10);
        @(negedge clk);
        check("cmp_outputs", 32'(outs), 32'(O_BUSY));
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort_cmp_idle", 32'(outs), 32'd0);
        check("abort_cmp_m0", 32'(mem[0]), 32'(N - 1));
        check("abort_cmp_m1", 32'(mem[1]), 32'(N - 2));

        // Abort in WR_I: WR_J still happens, then IDLE.
        load(1);
        pulse_start();
        wait_outs("reach_wr_i", O_MEMWR | O_ASEL, O_MEMWR, 20);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort_wr_j", 32'(outs), 32'(O_MEMWR | O_ASEL | O_BUSY));
        @(negedge clk);
        check("abort_wr_idle", 32'(outs), 32'd0);
        check("abort_wr_m0", 32'(mem[0]), 32'(N - 2));
        check("abort_wr_m1", 32'(mem[1]), 32'(N - 1));
`ifdef SORT_SWAP_CNT_EN
        check("abort_wr_swap_cnt", 32'(swap_cnt), 32'd1);
`endif
        repeat (3) @(negedge clk);
        check("abort_wr_stays_idle", 32'(outs), 32'd0);

        // Back-to-back: start held through DONE restarts after one IDLE cycle.
        load(0);
        done_q.push_back('{BASE_CYC, 0});
        done_q.push_back('{BASE_CYC, 0});
        @(negedge clk) start = 1'b1;
        wait_outs("b2b_done1", O_DONE, O_DONE, 4000);
        @(negedge clk);
        check("b2b_idle_gap", 32'(outs), 32'd0);
        @(negedge clk) start = 1'b0;
        check("b2b_init", 32'(outs), 32'(O_INZP1 | O_INZP2 | O_BUSY));
        for (int n = 0; n < 5; n++) begin
            repeat (100) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        wait_outs("b2b_done2", O_DONE, O_DONE, 4000);
        repeat (2) @(negedge clk);
        check("b2b_final_idle", 32'(outs), 32'd0);

        check("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
